alu_issue_unit: RTL
===================

# alu_issue_unit

Registered ALU issue stage that replaces the combinational ALU control path. It decodes an 8-bit instruction, selects the operand from the stack or from a parametrised bank of DC channels, and computes the result in the embedded ALU. It holds the carry and overflow flags and presents the result through a valid/ready output register. It sits between the instruction dispatch stage and the stack writeback. Multi-cycle multiply is an optional build feature.

## Interface
- `WORD_WIDTH`, 32, datapath width; ≥ 8, power of two
- `DC_COUNT`, 4, number of DC channels; power of two, 2..16
- `DC_SEL_W`, `$clog2(DC_COUNT)`, derived width of the DC select
- `clk` input 1: single clock, all state on rising edge
- `reset_n` input 1: synchronous, active-low reset
- `in_valid` input 1: instruction and operands valid
- `in_ready` output 1: unit accepts this cycle
- `instruction` input 8: opcode, `I_*` encodings from `instructions.sv`
- `dc_sel` input DC_SEL_W: DC channel for `I_RREADZ` / `I_RWRITEZ` / `I_ADDZ`
- `top` input WORD_WIDTH: stack top, ALU operand B
- `second` input WORD_WIDTH: stack second
- `dcs` input DC_COUNT×WORD_WIDTH: DC addresses
- `dc_vals` input DC_COUNT×WORD_WIDTH: DC values
- `out_valid` output 1: `result` valid
- `out_ready` input 1: consumer takes result
- `result` output WORD_WIDTH: registered ALU result
- `carry` output 1: carry flag register
- `overflow` output 1: overflow flag register
- `busy` output 1: multi-cycle operation in progress

## Operation
- **Handshake and flags**
  - Accept occurs on `in_valid && in_ready`.
  - `in_ready = reset_n && state==IDLE && (!out_valid || out_ready)`.
  - Single-cycle ops: `result`, `out_valid=1` and the flag updates are all captured on the accepting edge.
  - The flags produced by op N are visible to op N+1 accepted on the next cycle. No hazard bubble.
- **Operand A and carry-in**: same decode as before, generalised.
  - `dcs[dc_sel]` for RREADZ/RWRITEZ.
  - `dc_vals[dc_sel]` for ADDZ.
  - Constant 1 / −1 / 0 for INC/DEC/CARRY.
  - `~second` with ic=1 for SUB, ic=`carry` for SUBC.
  - `second` otherwise.
- **Add**
  - Computation: `{c, r} = A + top + ic`, computed at WORD_WIDTH+1 bits.
  - Overflow: `overflow = (A[msb]==top[msb]) && (r[msb]!=A[msb])`.
  - Flags are written only for ops whose old store_carry/store_overflow was 1. RREADZ, RWRITEZ and all logic ops leave the flags unchanged.
- **Shifts**
  - Amount is `second mod WORD_WIDTH`, i.e. only the low log2(WORD_WIDTH) bits are used.
  - LSL/LSR fill with zeros, ASR fills with `top[msb]`, CSL/CSR rotate.
  - Amount 0 returns `top`.
- **INV** returns `~top`.
- **Unrecognised opcode** passes `top` through, flags unchanged, and still produces `out_valid`.
- **States**
  - IDLE: accept MUL → MUL (only with ALU_MUL_EN).
  - MUL: step counter reaches WORD_WIDTH → IDLE, with result captured and `out_valid=1`.
  - `busy = (state==MUL)`.
- **Output register**
  - Holds while `out_valid && !out_ready`.
  - Clears `out_valid` on `out_ready` unless a new accept occurs on the same edge. A simultaneous take-and-accept keeps `out_valid=1` with the new result.
- **Reset** (`reset_n=0` at an edge), applied in any state including mid-MUL:
  - state → IDLE, step counter → 0.
  - `out_valid=0`, `result=0`, `carry=0`, `overflow=0`, `busy=0`.
  - `in_ready=0` while `reset_n` is low.

## Timing
- Single-cycle ops: 1-cycle latency. `out_valid` rises on the edge that accepts.
- Throughput: 1 op/cycle when `out_ready=1`.
- MUL: `out_valid` rises exactly WORD_WIDTH+1 edges after the accepting edge. `in_ready=0` throughout.
- `in_ready` is combinational on `out_ready`, `state` and `reset_n` only. There is no path from `in_valid` to `in_ready`.

## Configuration
- Macro: `ALU_ISSUE_MUL_EN`.
- **Defined**
  - `I_MUL` performs an unsigned shift-add multiply of `top*second`, one bit per cycle.
  - `result` = low WORD_WIDTH bits of the product.
  - `carry` = 1 iff the high half is nonzero; `overflow` unchanged.
- **Undefined**
  - `I_MUL` is handled as an unrecognised opcode, with 1-cycle latency.
  - The MUL state, step counter and multiplier registers are not synthesised, and `busy` is tied to 0.

## Test plan
All scenarios use WORD_WIDTH=32.

- **ADD carry**: ADD `top=0xFFFFFFFF`, `second=1` → next edge `result=0`, `carry=1`, `overflow=0`, `out_valid=1`.
- **ADD overflow, then ADDC**: ADD `0x7FFFFFFF+1` → `0x80000000`, `overflow=1`, `carry=0`. A back-to-back ADDC `top=5`, `second=0` then gives 5.
- **Backpressure**: SUB `top=10`, `second=3` with `out_ready=0` for 3 cycles → `result=7` held, `in_ready=0`. Releasing with a simultaneous new accept → no bubble.
- **Shifts**:
  - CSL `top=0x80000001`, `second=4` → `0x00000018`.
  - LSL `top=1`, `second=33` → `0x00000002`.
  - ASR `top=0x80000000`, `second=31` → `0xFFFFFFFF`.
- **DC select**: DC_COUNT=8, RREADZ `dc_sel=5`, `dcs[5]=0x100`, `top=0x20` → `0x120`, flags unchanged from prior values.
- **MUL** (with `ALU_ISSUE_MUL_EN`):
  - `0x10000*0x10000` → `result=0`, `carry=1`, `out_valid` exactly 33 edges after accept.
  - A repeat with `reset_n=0` at edge 10 → `busy=0`, `out_valid=0`, `carry=0`; a new ADD is accepted on the first edge after reset release.

Source files
------------

// File: rtl/alu_issue_unit.sv
// rtl/alu_issue_unit.sv - registered ALU issue stage with flags and valid/ready output
// Optional shift-add multiply enabled by defining ALU_ISSUE_MUL_EN.
module alu_issue_unit #(
  parameter int WORD_WIDTH = 32,
  parameter int DC_COUNT   = 4,
  parameter int DC_SEL_W   = $clog2(DC_COUNT)
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [7:0]                       instruction,
  input  logic [DC_SEL_W-1:0]              dc_sel,
  input  logic [WORD_WIDTH-1:0]            top,
  input  logic [WORD_WIDTH-1:0]            second,
  input  logic [DC_COUNT*WORD_WIDTH-1:0]   dcs,
  input  logic [DC_COUNT*WORD_WIDTH-1:0]   dc_vals,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WORD_WIDTH-1:0]            result,
  output logic                             carry,
  output logic                             overflow,
  output logic                             busy
);
  localparam int SH_W = $clog2(WORD_WIDTH);

  localparam logic [7:0] I_ADD     = 8'h01;
  localparam logic [7:0] I_ADDC    = 8'h02;
  localparam logic [7:0] I_SUB     = 8'h03;
  localparam logic [7:0] I_SUBC    = 8'h04;
  localparam logic [7:0] I_INC     = 8'h05;
  localparam logic [7:0] I_DEC     = 8'h06;
  localparam logic [7:0] I_CARRY   = 8'h07;
  localparam logic [7:0] I_ADDZ    = 8'h08;
  localparam logic [7:0] I_RREADZ  = 8'h09;
  localparam logic [7:0] I_RWRITEZ = 8'h0A;
  localparam logic [7:0] I_AND     = 8'h10;
  localparam logic [7:0] I_OR      = 8'h11;
  localparam logic [7:0] I_XOR     = 8'h12;
  localparam logic [7:0] I_INV     = 8'h13;
  localparam logic [7:0] I_LSL     = 8'h20;
  localparam logic [7:0] I_LSR     = 8'h21;
  localparam logic [7:0] I_ASR     = 8'h22;
  localparam logic [7:0] I_CSL     = 8'h23;
  localparam logic [7:0] I_CSR     = 8'h24;
  localparam logic [7:0] I_MUL     = 8'h30;

  logic [WORD_WIDTH-1:0] dc_addr_arr [DC_COUNT];
  logic [WORD_WIDTH-1:0] dc_val_arr  [DC_COUNT];

  for (genvar g = 0; g < DC_COUNT; g++) begin : g_dc
    assign dc_addr_arr[g] = dcs[g*WORD_WIDTH +: WORD_WIDTH];
    assign dc_val_arr[g]  = dc_vals[g*WORD_WIDTH +: WORD_WIDTH];
  end

  logic [WORD_WIDTH-1:0]   op_a;
  logic                    ic;
  logic                    is_add;
  logic                    store_flags;
  logic [WORD_WIDTH:0]     sum;
  logic                    add_ovf;
  logic [SH_W-1:0]         amt;
  logic [2*WORD_WIDTH-1:0] rot_l;
  logic [2*WORD_WIDTH-1:0] rot_r;
  logic [WORD_WIDTH-1:0]   alu_res;
  logic                    accept;
  logic                    mul_start;

  always_comb begin
    op_a        = second;
    ic          = 1'b0;
    is_add      = 1'b1;
    store_flags = 1'b1;
    case (instruction)
      I_ADD:                op_a = second;
      I_ADDC:               ic = carry;
      I_SUB:   begin op_a = ~second; ic = 1'b1;  end
      I_SUBC:  begin op_a = ~second; ic = carry; end
      I_INC:                op_a = {{(WORD_WIDTH-1){1'b0}}, 1'b1};
      I_DEC:                op_a = '1;
      I_CARRY: begin op_a = '0; ic = carry; end
      I_ADDZ:               op_a = dc_val_arr[dc_sel];
      I_RREADZ, I_RWRITEZ: begin
        op_a        = dc_addr_arr[dc_sel];
        store_flags = 1'b0;
      end
      default: begin
        is_add      = 1'b0;
        store_flags = 1'b0;
      end
    endcase
  end

  assign sum     = {1'b0, op_a} + {1'b0, top} + {{WORD_WIDTH{1'b0}}, ic};
  assign add_ovf = (op_a[WORD_WIDTH-1] == top[WORD_WIDTH-1]) &&
                   (sum[WORD_WIDTH-1] != op_a[WORD_WIDTH-1]);
  assign amt     = second[SH_W-1:0];
  // Rotates via a doubled word so amount 0 naturally yields top.
  assign rot_l   = {top, top} << amt;
  assign rot_r   = {top, top} >> amt;

  always_comb begin
    alu_res = top;
    if (is_add) begin
      alu_res = sum[WORD_WIDTH-1:0];
    end else begin
      case (instruction)
        I_AND:   alu_res = top & second;
        I_OR:    alu_res = top | second;
        I_XOR:   alu_res = top ^ second;
        I_INV:   alu_res = ~top;
        I_LSL:   alu_res = top << amt;
        I_LSR:   alu_res = top >> amt;
        I_ASR:   alu_res = $signed(top) >>> amt;
        I_CSL:   alu_res = rot_l[2*WORD_WIDTH-1:WORD_WIDTH];
        I_CSR:   alu_res = rot_r[WORD_WIDTH-1:0];
        default: alu_res = top;
      endcase
    end
  end

`ifdef ALU_ISSUE_MUL_EN
  typedef enum logic {IDLE, MUL} state_t;
  localparam logic [SH_W:0] CNT_DONE = (SH_W+1)'(WORD_WIDTH);

  state_t                  state;
  logic [SH_W:0]           cnt;
  logic [2*WORD_WIDTH-1:0] acc;
  logic [2*WORD_WIDTH-1:0] mcand;
  logic [WORD_WIDTH-1:0]   mplier;

  assign in_ready  = reset_n && (state == IDLE) && (!out_valid || out_ready);
  assign mul_start = accept && (instruction == I_MUL);
  assign busy      = (state == MUL);
`else
  assign in_ready  = reset_n && (!out_valid || out_ready);
  assign mul_start = 1'b0;
  assign busy      = 1'b0;
`endif

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
`ifdef ALU_ISSUE_MUL_EN
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
`endif
    end else begin
      if (accept && !mul_start) begin
        out_valid <= 1'b1;
        result    <= alu_res;
        if (store_flags) begin
          carry    <= sum[WORD_WIDTH];
          overflow <= add_ovf;
        end
      end else if (accept || out_ready) begin
        out_valid <= 1'b0;
      end
`ifdef ALU_ISSUE_MUL_EN
      if (mul_start) begin
        state  <= MUL;
        cnt    <= '0;
        acc    <= '0;
        mcand  <= {{WORD_WIDTH{1'b0}}, top};
        mplier <= second;
      end
      // One multiplier bit per edge; the edge after the last bit publishes the product.
      if (state == MUL) begin
        if (cnt == CNT_DONE) begin
          state     <= IDLE;
          result    <= acc[WORD_WIDTH-1:0];
          carry     <= |acc[2*WORD_WIDTH-1:WORD_WIDTH];
          out_valid <= 1'b1;
        end else begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
        end
      end
`endif
    end
  end
endmodule
